// File: rtl/data_memory_ctrl_if.sv
// Request/response bus for data_memory_ctrl; req_be exists only when
// GFORCE_BYTE_ENABLE_EN is defined.
interface data_memory_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and payload holds while valid=1 and ready=0.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef GFORCE_BYTE_ENABLE_EN
  logic [DATA_W/8-1:0] req_be;
`endif
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

`ifdef GFORCE_BYTE_ENABLE_EN
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
`endif
endinterface

// File: rtl/data_memory_ctrl.sv
// Single-outstanding word memory with programmable wait states and range error.
// Optional byte-enable writes are compiled in with GFORCE_BYTE_ENABLE_EN.
module data_memory_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 128,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset,
  data_memory_ctrl_if.slave   bus,
  output logic [1:0]          fsm_state
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
`ifdef GFORCE_BYTE_ENABLE_EN
  logic [DATA_W/8-1:0] lat_be;
  logic [DATA_W/8-1:0] acc_be;
`endif

  // Contents start at zero and survive reset.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              accept;
  logic              enter_resp;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;

  // With zero wait states the access happens on the accept edge itself, so the
  // operands come straight from the bus in IDLE and from the latches otherwise.
  always_comb begin
    accept     = (state == IDLE) && bus.req_valid && req_ready_q;
    enter_resp = 1'b0;
    if (state == IDLE)      enter_resp = accept && (WAIT_CYCLES == 0);
    else if (state == WAIT) enter_resp = (cnt == 4'd0);
    acc_we    = (state == IDLE) ? bus.req_we    : lat_we;
    acc_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
    acc_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;
    in_range  = (acc_addr < DEPTH_A);
    idx       = acc_addr[IDX_W-1:0];
    rd_word   = mem[idx];
    wr_word   = acc_wdata;
`ifdef GFORCE_BYTE_ENABLE_EN
    acc_be = (state == IDLE) ? bus.req_be : lat_be;
    for (int i = 0; i < DATA_W / 8; i++) begin
      wr_word[8*i +: 8] = acc_be[i] ? acc_wdata[8*i +: 8] : rd_word[8*i +: 8];
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      if (enter_resp) begin
        state        <= RESP;
        resp_valid_q <= 1'b1;
        resp_rdata_q <= (!acc_we && in_range) ? rd_word : '0;
        resp_err_q   <= !in_range;
      end
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            lat_we      <= bus.req_we;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
`ifdef GFORCE_BYTE_ENABLE_EN
            lat_be      <= bus.req_be;
`endif
            if (WAIT_CYCLES != 0) begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writes commit only on the edge entering RESP; reset in WAIT abandons them.
  always_ff @(posedge clock) begin
    if (!reset && enter_resp && acc_we && in_range) mem[idx] <= wr_word;
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign fsm_state      = state;
endmodule
